// File: rtl/vote_session_ctrl.sv
// rtl/vote_session_ctrl.sv - ballot-session controller: debounce, one vote per press, lockout, result select
// Optional officer arming via `define VOTER_AUTH_EN (adds voter_en port).
module vote_session_ctrl #(
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
`ifdef VOTER_AUTH_EN
  input  logic       voter_en,
`endif
  output logic [3:0] vote_inc,
  output logic [1:0] disp_sel,
  output logic       disp_valid,
  output logic       busy,
  output logic       multi_err
);

  localparam int DB_MAX  = (DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES : 2;
  localparam int LK_MAX  = (LOCKOUT_CYCLES > 2) ? LOCKOUT_CYCLES : 2;
  localparam int DB_W    = $clog2(DB_MAX) + 1;
  localparam int LK_W    = $clog2(LK_MAX) + 1;
  localparam int CNT_W   = (DB_W > LK_W) ? DB_W : LK_W;
  localparam int LK_LAST = (LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_GRANT,
    S_WAIT_REL,
    S_LOCKOUT,
    S_RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       disp_sel_q, disp_sel_d;
  logic [3:0]       vote_inc_q, vote_inc_d;
  logic             disp_valid_q, disp_valid_d;
  logic             busy_q, busy_d;
  logic             multi_err_q, multi_err_d;
  logic [1:0]       rst_sync_q;
  logic             rst_n_int;
  logic [3:0]       btn_s1_q, btn_s2_q;
  logic             mode_s1_q, mode_s2_q;
  logic             armed;
  logic             single;
  logic             multi;
  logic [1:0]       btn_idx;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      btn_s1_q  <= 4'b0000;
      btn_s2_q  <= 4'b0000;
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
    end else begin
      btn_s1_q  <= {button4, button3, button2, button1};
      btn_s2_q  <= btn_s1_q;
      mode_s1_q <= mode;
      mode_s2_q <= mode_s1_q;
    end
  end

  function automatic logic [1:0] enc(input logic [3:0] b);
    enc = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (b[i]) enc = 2'(i);
    end
  endfunction

  assign single  = (btn_s2_q != 4'd0) && ((btn_s2_q & (btn_s2_q - 4'd1)) == 4'd0);
  assign multi   = (btn_s2_q != 4'd0) && !single;
  assign btn_idx = enc(btn_s2_q);

`ifdef VOTER_AUTH_EN
  logic arm_q, arm_d;
  assign armed = arm_q;
`else
  assign armed = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    disp_sel_d  = disp_sel_q;
    multi_err_d = 1'b0;
`ifdef VOTER_AUTH_EN
    arm_d       = arm_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef VOTER_AUTH_EN
        if (voter_en) arm_d = 1'b1;
`endif
        if (mode_s2_q) begin
          state_d = S_RESULT;
        end else if (armed && single) begin
          state_d = S_DEBOUNCE;
          idx_d   = btn_idx;
          cnt_d   = CNT_W'(1);
        end else if (armed && multi) begin
          state_d     = S_WAIT_REL;
          multi_err_d = 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (mode_s2_q) begin
          state_d = S_RESULT;
        end else if (multi) begin
          state_d     = S_WAIT_REL;
          multi_err_d = 1'b1;
        end else if (!btn_s2_q[idx_q]) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_d = S_GRANT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GRANT: begin
        state_d = S_WAIT_REL;
`ifdef VOTER_AUTH_EN
        arm_d   = 1'b0;
`endif
      end
      S_WAIT_REL: begin
        if (mode_s2_q) begin
          state_d = S_RESULT;
        end else if (btn_s2_q == 4'd0) begin
          state_d = (LOCKOUT_CYCLES == 0) ? S_IDLE : S_LOCKOUT;
          cnt_d   = '0;
        end
      end
      S_LOCKOUT: begin
        if (mode_s2_q) begin
          state_d = S_RESULT;
        end else if (cnt_q == CNT_W'(LK_LAST)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESULT: begin
        // Leaving through WAIT_REL forces a release before any button can vote.
        if (!mode_s2_q) begin
          state_d = S_WAIT_REL;
        end else if (single) begin
          disp_sel_d = btn_idx;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef VOTER_AUTH_EN
    if ((state_d == S_RESULT) && (state_q != S_RESULT)) arm_d = 1'b0;
`endif
    vote_inc_d   = (state_d == S_GRANT) ? (4'b0001 << idx_d) : 4'b0000;
    disp_valid_d = (state_d == S_RESULT);
    busy_d       = (state_d == S_DEBOUNCE) || (state_d == S_GRANT) ||
                   (state_d == S_WAIT_REL) || (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      disp_sel_q   <= 2'd0;
      vote_inc_q   <= 4'd0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      multi_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_sel_q   <= disp_sel_d;
      vote_inc_q   <= vote_inc_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
      multi_err_q  <= multi_err_d;
    end
  end

`ifdef VOTER_AUTH_EN
  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) arm_q <= 1'b0;
    else            arm_q <= arm_d;
  end
`endif

  assign vote_inc   = vote_inc_q;
  assign disp_sel   = disp_sel_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;
  assign multi_err  = multi_err_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// tb/tb_vote_session_ctrl.sv - bench for vote_session_ctrl: vector table plus event scoreboard
module tb_vote_session_ctrl;

  localparam int DEB = 10;
  localparam int LCK = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       mode;
  logic [3:0] btn_raw;
  logic       voter_en;
  logic [3:0] vote_inc;
  logic [1:0] disp_sel;
  logic       disp_valid;
  logic       busy;
  logic       multi_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [3:0] btn;
    int         hold;
    logic [3:0] exp_vote;
    logic       exp_merr;
    logic       chk_busy;
  } vec_t;

  typedef struct {
    logic [3:0] vote;
    logic       merr;
    int         cyc;
  } ev_t;

  ev_t  sbq[$];
  vec_t vecs[8];

  vote_session_ctrl #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LCK)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .mode       (mode),
    .button1    (btn_raw[0]),
    .button2    (btn_raw[1]),
    .button3    (btn_raw[2]),
    .button4    (btn_raw[3]),
`ifdef VOTER_AUTH_EN
    .voter_en   (voter_en),
`endif
    .vote_inc   (vote_inc),
    .disp_sel   (disp_sel),
    .disp_valid (disp_valid),
    .busy       (busy),
    .multi_err  (multi_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Any vote or multi-press pulse must match the next expected event, cycle-exact.
  always @(negedge clock) begin
    if (vote_inc != 4'd0 || multi_err) begin
      if (sbq.size() == 0) begin
        checks   = checks + 1;
        failures = failures + 1;
        $display("FAIL unexpected_event vote_inc=%b multi_err=%b cycle=%0d required no event",
                 vote_inc, multi_err, cyc);
      end else begin
        ev_t ev;
        ev = sbq.pop_front();
        chk("event_vote_inc", int'(vote_inc), int'(ev.vote));
        chk("event_multi_err", int'(multi_err), int'(ev.merr));
        chk("event_cycle", cyc, ev.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic arm();
`ifdef VOTER_AUTH_EN
    step();
    voter_en = 1'b1;
    step();
    voter_en = 1'b0;
`endif
  endtask

  task automatic run_row(input vec_t v);
    int r;
    int l;
    step();
    btn_raw = v.btn;
    r = cyc;
    if (v.exp_vote != 4'd0) sbq.push_back('{v.exp_vote, 1'b0, r + DEB + 3});
    if (v.exp_merr) sbq.push_back('{4'd0, 1'b1, r + 3});
    repeat (v.hold) step();
    btn_raw = 4'd0;
    l = cyc;
    if (v.chk_busy) begin
      // release synced at l+2, then LCK lockout cycles
      repeat (LCK + 2) step();
      chk("busy_end_of_lockout", int'(busy), 1);
      step();
      chk("busy_after_lockout", int'(busy), 0);
    end else begin
      repeat (LCK + 9) step();
      chk("busy_settled", int'(busy), 0);
    end
    chk("scoreboard_drained", sbq.size(), 0);
    if (l < 0) chk("neg_cycle", l, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int x;
    vecs[0] = '{4'b0001, 20, 4'b0001, 1'b0, 1'b1};
    vecs[1] = '{4'b0010, 20, 4'b0010, 1'b0, 1'b1};
    vecs[2] = '{4'b0100, 11, 4'b0100, 1'b0, 1'b0};
    vecs[3] = '{4'b1000, 10, 4'b0000, 1'b0, 1'b0};
    vecs[4] = '{4'b0110, 20, 4'b0000, 1'b1, 1'b1};
    vecs[5] = '{4'b1001,  5, 4'b0000, 1'b1, 1'b1};
    vecs[6] = '{4'b0001,  5, 4'b0000, 1'b0, 1'b0};
    vecs[7] = '{4'b1111,  3, 4'b0000, 1'b1, 1'b1};

    reset_n  = 1'b0;
    mode     = 1'b0;
    btn_raw  = 4'd0;
    voter_en = 1'b0;
    repeat (10) step();
    chk("reset_vote_inc", int'(vote_inc), 0);
    chk("reset_disp_sel", int'(disp_sel), 0);
    chk("reset_disp_valid", int'(disp_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_multi_err", int'(multi_err), 0);
    reset_n = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 8; i++) begin
      arm();
      run_row(vecs[i]);
    end

    // Short bouncing presses never reach a vote.
    arm();
    for (int k = 0; k < 3; k++) begin
      btn_raw = 4'b0001;
      repeat (5) step();
      btn_raw = 4'b0000;
      repeat (5) step();
    end
    repeat (25) step();
    chk("bounce_busy", int'(busy), 0);
    chk("bounce_drained", sbq.size(), 0);

    // Result mode: selection without debounce, multi-press ignored, held button never votes.
    mode    = 1'b1;
    btn_raw = 4'b0010;
    repeat (6) step();
    chk("result_disp_valid", int'(disp_valid), 1);
    chk("result_disp_sel_b2", int'(disp_sel), 1);
    chk("result_busy", int'(busy), 0);
    btn_raw = 4'b1000;
    repeat (4) step();
    chk("result_disp_sel_b4", int'(disp_sel), 3);
    btn_raw = 4'b0110;
    repeat (4) step();
    chk("result_multi_keeps_sel", int'(disp_sel), 3);
    btn_raw = 4'b0010;
    repeat (4) step();
    chk("result_disp_sel_b2_again", int'(disp_sel), 1);
    mode = 1'b0;
    repeat (30) step();
    chk("after_result_disp_valid", int'(disp_valid), 0);
    chk("after_result_busy_held", int'(busy), 1);
    chk("disp_sel_retained", int'(disp_sel), 1);
    btn_raw = 4'b0000;
    repeat (25) step();
    chk("after_result_released", int'(busy), 0);
    arm();
    run_row('{4'b0010, 20, 4'b0010, 1'b0, 1'b1});

    // Reset in the middle of a debounce, button kept high across it.
    arm();
    step();
    btn_raw = 4'b0001;
    repeat (7) step();
    chk("mid_debounce_busy", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_vote_inc", int'(vote_inc), 0);
    chk("async_reset_disp_sel", int'(disp_sel), 0);
    chk("async_reset_disp_valid", int'(disp_valid), 0);
    chk("async_reset_multi_err", int'(multi_err), 0);
`ifdef VOTER_AUTH_EN
    voter_en = 1'b1;
`endif
    repeat (3) step();
    reset_n = 1'b1;
    x = cyc;
    sbq.push_back('{4'b0001, 1'b0, x + DEB + 5});
    repeat (4) step();
    voter_en = 1'b0;
    repeat (16) step();
    btn_raw = 4'b0000;
    repeat (25) step();
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_drained", sbq.size(), 0);

`ifdef VOTER_AUTH_EN
    run_row('{4'b0100, 20, 4'b0000, 1'b0, 1'b0});
    arm();
    run_row('{4'b0100, 20, 4'b0100, 1'b0, 1'b1});
    run_row('{4'b0100, 20, 4'b0000, 1'b0, 1'b0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
